serial_compare_sequencer: RTL
=============================

// Module: serial_compare_sequencer
// PURPOSE
//  Sequences one external 2-bit magnitude comparator slice (gt/eq/lt flags) to compare two
//  WIDTH-bit operands MSB-first, one 2-bit slice per clock. Start/done handshake toward the
//  host. Registered gt/eq/lt result. Lets one small comparator serve wide operands.
// PARAMETERS
//  WIDTH   8   operand width; must be even, >= 2; NSLICE = WIDTH/2 slices
// PORTS
//  clk        in   1      rising-edge clock
//  rst_n      in   1      synchronous reset, active-low
//  start      in   1      request; accepted only in IDLE
//  a          in   WIDTH  operand A, sampled on accepted start
//  b          in   WIDTH  operand B, sampled on accepted start
//  slice_a    out  2      A slice to comparator (A=bit1, B=bit0 of slice)
//  slice_b    out  2      B slice to comparator (C=bit1, D=bit0 of slice)
//  slice_gt   in   1      comparator F1 (slice_a > slice_b), combinational same cycle
//  slice_eq   in   1      comparator F2 (slice_a == slice_b)
//  slice_lt   in   1      comparator F3 (slice_a < slice_b)
//  busy       out  1      high in COMPARE and DONE
//  done       out  1      one-cycle pulse, result valid
//  gt,eq,lt   out  1 ea   registered result, one-hot when valid; held until next accepted start
//  err        out  1      slice flags not one-hot during compare; held until next accepted start
// BEHAVIOUR
//  - Reset (rst_n=0 at edge): state=IDLE; busy, done, gt, eq, lt, err = 0; slice_a/b = 0.
//    Mid-operation reset aborts. No done pulse. Result cleared.
//  - States: IDLE -> COMPARE -> DONE -> IDLE.
//  - IDLE: on start=1:
//    - capture a,b into a_r,b_r; idx = NSLICE-1; clear gt/eq/lt/err/decided; -> COMPARE
//  - start is ignored in COMPARE and DONE. No queueing.
//  - COMPARE:
//    - slice_a = a_r[2*idx+1 -: 2], slice_b = b_r[2*idx+1 -: 2]
//    - slice_a/b are 0 in every other state.
//    - Flags not one-hot: err=1, gt/eq/lt=0, -> DONE immediately.
//    - !decided && slice_gt/lt: record gt/lt, set decided.
//    - decided: later slice flags ignored, still one-hot checked.
//    - idx==0 and !decided: eq=1.
//    - Leave COMPARE when idx==0, else idx--.
//    - EARLY_EXIT_EN exception: see CONFIGURATION.
//  - DONE: done=1 for exactly this cycle; -> IDLE next edge. Results stay valid in IDLE.
//  - Latency (start accepted at edge T):
//    - COMPARE occupies T+1..T+k, k = slices examined.
//    - done high in cycle T+k+1.
//    - Full run k=NSLICE (WIDTH=8: done at T+5).
//  - start held high continuously: a new operand pair is accepted on the edge leaving DONE->IDLE+1.
//    Throughput is one compare per k+2 cycles.
//  - gt/eq/lt change only on accepted start (clear) or during COMPARE. Never glitch in DONE or IDLE.
// CONFIGURATION
//  EARLY_EXIT_EN defined:
//    - first non-eq slice (or err) goes -> DONE on that edge; k = index of deciding slice from MSB + 1
//    - equal operands still take k=NSLICE
//  EARLY_EXIT_EN undefined:
//    - always k=NSLICE (constant latency)
//    - first decision is sticky
//    - err still exits immediately
// TESTING
//  - WIDTH=8, a=b=8'hA5:
//    - start at T -> slices 10,10,01,01 presented T+1..T+4
//    - done@T+5, eq=1, gt=lt=err=0
//  - a=8'hC0, b=8'h40 (MSB slice 11 vs 01):
//    - EN: done@T+2 gt=1
//    - no EN: done@T+5 gt=1, later slices ignored
//  - a=8'h12, b=8'h13 (LSB slice 10 vs 11) -> done@T+5 lt=1 both configs
//  - start pulsed at T+2 during compare: ignored; a/b changed after T: no effect on result
//  - start held high, two pairs (a=8'h01,b=8'h00) then (a=8'h00,b=8'h01) -> gt then lt, done pulses k+2 cycles apart
//  - rst_n=0 at T+2 mid-compare -> IDLE at T+3, all outputs 0, no done
//  - bench drives slice_gt=slice_lt=1 at first slice -> done@T+2 err=1 gt=eq=lt=0

Source files
------------

// File: rtl/serial_compare_sequencer.sv
// serial_compare_sequencer: compares two WIDTH-bit operands MSB-first
// by driving one external 2-bit comparator slice per clock.
//
// Optional feature macro: EARLY_EXIT_EN
//   defined   : leave COMPARE on the first non-equal slice
//   undefined : always examine all NSLICE slices (constant latency)
//
// Parameters:
//   WIDTH    operand width, even and >= 2 (NSLICE = WIDTH/2)
//
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   start               request, accepted only in IDLE
//   a, b                operands, captured on accepted start
//   slice_a, slice_b    current 2-bit slices toward the comparator
//   slice_gt/eq/lt      comparator flags for the current slice
//   busy                high in COMPARE and DONE
//   done                one-cycle pulse, result valid
//   gt, eq, lt, err     registered result, held until next start

module serial_compare_sequencer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [1:0]       slice_a,
  output logic [1:0]       slice_b,
  input  logic             slice_gt,
  input  logic             slice_eq,
  input  logic             slice_lt,
  output logic             busy,
  output logic             done,
  output logic             gt,
  output logic             eq,
  output logic             lt,
  output logic             err
);

  localparam int NSLICE = WIDTH / 2;
  localparam int IW = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [IW-1:0] LAST = IW'(NSLICE - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COMPARE = 2'd1,
    DONE    = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic [IW-1:0]    idx;
  logic             decided;

  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic             in_cmp;
  logic             flags_ok;
  logic             hit;
  logic             last_slice;
  logic             leave;

  // Shifting instead of an indexed part-select keeps the
  // slice mux free of index-width mismatches.
  assign a_sh   = a_r >> {idx, 1'b0};
  assign b_sh   = b_r >> {idx, 1'b0};
  assign in_cmp = (state == COMPARE);

  assign slice_a = in_cmp ? a_sh[1:0] : 2'b00;
  assign slice_b = in_cmp ? b_sh[1:0] : 2'b00;

  always_comb begin
    flags_ok = 1'b0;
    unique case ({slice_gt, slice_eq, slice_lt})
      3'b100:  flags_ok = 1'b1;
      3'b010:  flags_ok = 1'b1;
      3'b001:  flags_ok = 1'b1;
      default: flags_ok = 1'b0;
    endcase
  end

  // First non-equal slice settles the result; later ones are ignored.
  assign hit        = !decided && (slice_gt || slice_lt);
  assign last_slice = (idx == '0);

`ifdef EARLY_EXIT_EN
  assign leave = last_slice || hit;
`else
  assign leave = last_slice;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      a_r     <= '0;
      b_r     <= '0;
      idx     <= '0;
      decided <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      gt      <= 1'b0;
      eq      <= 1'b0;
      lt      <= 1'b0;
      err     <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            a_r     <= a;
            b_r     <= b;
            idx     <= LAST;
            decided <= 1'b0;
            gt      <= 1'b0;
            eq      <= 1'b0;
            lt      <= 1'b0;
            err     <= 1'b0;
            busy    <= 1'b1;
            state   <= COMPARE;
          end
        end
        COMPARE: begin
          if (!flags_ok) begin
            // Untrustworthy comparator: flag and bail out.
            err   <= 1'b1;
            gt    <= 1'b0;
            eq    <= 1'b0;
            lt    <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end else begin
            if (hit) begin
              gt      <= slice_gt;
              lt      <= slice_lt;
              decided <= 1'b1;
            end
            if (last_slice && !decided && slice_eq) begin
              eq <= 1'b1;
            end
            if (leave) begin
              done  <= 1'b1;
              state <= DONE;
            end else begin
              idx <= idx - 1'b1;
            end
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
